reg_pipe: RTL

- Parametrised pipeline register for the cache datapath, succeeding the single-bit pass-through flop.
- Chain of DEPTH register slices, each WIDTH bits wide, with valid/ready handshake, full throughput and registered backpressure (skid buffer per stage).
- Adds synchronous flush and an occupancy count.
- Used to retime tag/data paths between cache pipeline stages without combinational ready paths.

---
 rtl/cache_pkg.sv | 18 +
 rtl/reg_slice.sv | 77 +++++++
 rtl/reg_pipe.sv | 76 +++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache datapath pipeline registers.
//   count_width()  : width of an occupancy counter able to hold 0..2*depth
//   slice_state_e  : per-slice state, encoded as {main_valid, skid_valid}
package cache_pkg;

  // Each slice holds up to two beats (main + skid), so occupancy spans 0..2*depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

  // Bit 1 is main_valid and bit 0 is skid_valid. 2'b01 is not a legal state.
  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'b00,
    SLICE_BUSY  = 2'b10,
    SLICE_FULL  = 2'b11
  } slice_state_e;

endpackage

// File: rtl/reg_slice.sv
// One skid-buffered register slice. Backpressure is registered: up_ready comes
// straight from the skid-valid flop, so there is no combinational ready path.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   flush                    drop all held beats (data registers keep their values)
//   up_valid/up_ready/up_data         upstream handshake
//   down_valid/down_ready/down_data   downstream handshake (driven from main)
module reg_slice
  import cache_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data
);

  slice_state_e     state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             up_fire;
  logic             down_fire;

  assign up_ready   = ~state_q[0];
  assign down_valid = state_q[1];
  assign down_data  = main_q;
  assign up_fire    = up_valid & up_ready;
  assign down_fire  = down_valid & down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLICE_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else if (flush) begin
      // A beat accepted this cycle is dropped; data registers are left alone.
      state_q <= SLICE_EMPTY;
    end else begin
      unique case (state_q)
        SLICE_EMPTY: begin
          if (up_fire) begin
            state_q <= SLICE_BUSY;
            main_q  <= up_data;
          end
        end
        SLICE_BUSY: begin
          if (up_fire && down_fire) begin
            main_q <= up_data;
          end else if (up_fire) begin
            state_q <= SLICE_FULL;
            skid_q  <= up_data;
          end else if (down_fire) begin
            state_q <= SLICE_EMPTY;
          end
        end
        SLICE_FULL: begin
          if (down_fire) begin
            state_q <= SLICE_BUSY;
            main_q  <= skid_q;
          end
        end
        default: state_q <= SLICE_EMPTY;
      endcase
    end
  end

  // A skid beat without a main beat would reorder data.
  illegal_state_a : assert property (@(posedge clk) disable iff (rst) state_q != 2'b01);

endmodule

// File: rtl/reg_pipe.sv
// Parametrised pipeline register: DEPTH skid-buffered slices in a chain, full
// throughput, registered backpressure, synchronous flush and an occupancy count.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   flush              synchronous clear of all held beats
//   in_valid/in_ready/in_data     upstream handshake (in_ready from a flop)
//   out_valid/out_ready/out_data  downstream handshake (tail slice main)
//   count              beats held, 0..2*DEPTH
module reg_pipe
  import cache_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  input  logic                            out_ready,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int unsigned CountW = count_width(DEPTH);

  // Link i feeds slice i; link DEPTH is the tail.
  logic             link_valid [DEPTH+1];
  logic             link_ready [DEPTH+1];
  logic [WIDTH-1:0] link_data  [DEPTH+1];

  assign link_valid[0]     = in_valid;
  assign link_data[0]      = in_data;
  assign in_ready          = link_ready[0];
  assign out_valid         = link_valid[DEPTH];
  assign out_data          = link_data[DEPTH];
  assign link_ready[DEPTH] = out_ready;

  for (genvar s = 0; s < DEPTH; s++) begin : g_slice
    reg_slice #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (link_valid[s]),
      .up_ready   (link_ready[s]),
      .up_data    (link_data[s]),
      .down_valid (link_valid[s+1]),
      .down_ready (link_ready[s+1]),
      .down_data  (link_data[s+1])
    );
  end

  logic              in_fire;
  logic              out_fire;
  logic [CountW-1:0] count_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign count    = count_q;

  // Bounds are structural: in_ready is low when full, out_valid low when empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CountW'(in_fire) - CountW'(out_fire);
    end
  end

endmodule
